// File: rtl/simon_fifo_to_axi_wr_if.sv
// Command, FIFO-drain and AXI4 write-channel bundle for simon_fifo_to_axi_wr.
// master = the write engine, slave = interconnect/FIFO/command side.
interface simon_fifo_to_axi_wr_if #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int RESP_WIDTH = 2,
  parameter int STRB_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
);
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [CNT_WIDTH-1:0]  cmd_len;
  logic                  cmd_vld;
  logic                  cmd_rdy;
  logic                  done;
  logic                  err;

  logic [DATA_WIDTH-1:0] fifo_din;
  logic                  fifo_vld;
  logic                  fifo_rdy;

  logic [ADDR_WIDTH-1:0] awaddr;
  logic [LEN_WIDTH-1:0]  awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic [3:0]            awcache;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;

  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;

  logic [RESP_WIDTH-1:0] bresp;
  logic                  bvalid;
  logic                  bready;

  modport master (
    input  cmd_addr, cmd_len, cmd_vld, fifo_din, fifo_vld,
           awready, wready, bresp, bvalid,
    output cmd_rdy, done, err, fifo_rdy,
           awaddr, awlen, awsize, awburst, awcache, awprot, awvalid,
           wdata, wstrb, wlast, wvalid, bready
  );

  modport slave (
    output cmd_addr, cmd_len, cmd_vld, fifo_din, fifo_vld,
           awready, wready, bresp, bvalid,
    input  cmd_rdy, done, err, fifo_rdy,
           awaddr, awlen, awsize, awburst, awcache, awprot, awvalid,
           wdata, wstrb, wlast, wvalid, bready
  );
endinterface

// File: rtl/simon_fifo_to_axi_wr.sv
// AXI4 write master: drains the Simon output FIFO into memory as 4 KB-safe INCR bursts,
// one burst outstanding at a time, pulsing done when the whole command has been written.
module simon_fifo_to_axi_wr #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int RESP_WIDTH = 2,
  parameter int STRB_WIDTH = 16,
  parameter int CNT_WIDTH  = 16,
  parameter int MAX_BURST  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  simon_fifo_to_axi_wr_if.master  bus
);

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_AW, S_W, S_B, S_DONE} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [CNT_WIDTH-1:0]  rem;
  logic [CNT_WIDTH-1:0]  burst;
  logic [LEN_WIDTH-1:0]  beat;
  logic [ADDR_WIDTH-1:0] awaddr_r;
  logic [LEN_WIDTH-1:0]  awlen_r;
  logic                  awvalid_r;
  logic                  in_w;
  logic                  last_r;
  logic                  bready_r;
  logic                  cmd_rdy_r;
  logic                  done_r;
  logic                  err_r;

  logic [8:0]            to_4k;
  logic [CNT_WIDTH-1:0]  burst_c;
  logic                  w_hs;

  // Beats left before the next 4 KB boundary (1..256), then clamp by MAX_BURST and remainder.
  always_comb begin
    to_4k   = 9'd256 - {1'b0, addr[11:4]};
    burst_c = rem;
    if (burst_c > CNT_WIDTH'(MAX_BURST)) burst_c = CNT_WIDTH'(MAX_BURST);
    if (burst_c > CNT_WIDTH'(to_4k))     burst_c = CNT_WIDTH'(to_4k);
  end

  assign w_hs = in_w & bus.fifo_vld & bus.wready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      addr      <= '0;
      rem       <= '0;
      burst     <= '0;
      beat      <= '0;
      awaddr_r  <= '0;
      awlen_r   <= '0;
      awvalid_r <= 1'b0;
      in_w      <= 1'b0;
      last_r    <= 1'b0;
      bready_r  <= 1'b0;
      cmd_rdy_r <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      unique case (state)
        S_IDLE: begin
          cmd_rdy_r <= 1'b1;
          if (bus.cmd_vld && cmd_rdy_r) begin
            cmd_rdy_r <= 1'b0;
            addr      <= bus.cmd_addr & ~ADDR_WIDTH'(15);
            rem       <= bus.cmd_len;
            err_r     <= 1'b0;
            state     <= S_CALC;
          end
        end
        S_CALC: begin
          if (rem == '0) begin
            done_r <= 1'b1;
            state  <= S_DONE;
          end else begin
            awaddr_r  <= addr;
            awlen_r   <= LEN_WIDTH'(burst_c - CNT_WIDTH'(1));
            burst     <= burst_c;
            beat      <= '0;
            last_r    <= (burst_c == CNT_WIDTH'(1));
            awvalid_r <= 1'b1;
            state     <= S_AW;
          end
        end
        S_AW: begin
          if (bus.awready && awvalid_r) begin
            awvalid_r <= 1'b0;
            in_w      <= 1'b1;
            state     <= S_W;
          end
        end
        S_W: begin
          if (w_hs) begin
            beat   <= beat + LEN_WIDTH'(1);
            last_r <= ((beat + LEN_WIDTH'(1)) == awlen_r);
            if (last_r) begin
              in_w     <= 1'b0;
              last_r   <= 1'b0;
              bready_r <= 1'b1;
              state    <= S_B;
            end
          end
        end
        S_B: begin
          if (bus.bvalid && bready_r) begin
            bready_r <= 1'b0;
            err_r    <= err_r | (bus.bresp != RESP_WIDTH'(0));
            addr     <= addr + (ADDR_WIDTH'(burst) << 4);
            rem      <= rem - burst;
            state    <= S_CALC;
          end
        end
        S_DONE: begin
          cmd_rdy_r <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // W valid follows the FIFO directly so a stalled beat never waits an extra cycle.
  assign bus.wvalid   = in_w & bus.fifo_vld;
  assign bus.fifo_rdy = w_hs;
  assign bus.wlast    = in_w & last_r;
  assign bus.wdata    = DATA_WIDTH'(bus.fifo_din);
  assign bus.wstrb    = {STRB_WIDTH{1'b1}};

  assign bus.awaddr   = awaddr_r;
  assign bus.awlen    = awlen_r;
  assign bus.awvalid  = awvalid_r;
  assign bus.awsize   = 3'd4;
  assign bus.awburst  = 2'b01;
  assign bus.awcache  = 4'b0011;
  assign bus.awprot   = 3'b000;

  assign bus.bready   = bready_r;
  assign bus.cmd_rdy  = cmd_rdy_r;
  assign bus.done     = done_r;
  assign bus.err      = err_r;

endmodule

// File: tb/tb_simon_fifo_to_axi_wr.sv
// Bench for simon_fifo_to_axi_wr: randomized FIFO/AXI responder plus a burst-list and
// data-queue reference model computed from the command.
`timescale 1ns/1ps
module tb_simon_fifo_to_axi_wr;
  localparam int DW = 128, AW = 32, LW = 8, RW = 2, SW = 16, CW = 16, MAXB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  simon_fifo_to_axi_wr_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW),
                            .RESP_WIDTH(RW), .STRB_WIDTH(SW), .CNT_WIDTH(CW)) bus ();

  simon_fifo_to_axi_wr #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .RESP_WIDTH(RW),
                         .STRB_WIDTH(SW), .CNT_WIDTH(CW), .MAX_BURST(MAXB))
    dut (.clk(clk), .rst(rst), .bus(bus.master));

  int vectors = 0, miscompares = 0, cyc = 0;
  int aw_stall = 0, w_stall = 0, b_stall = 0, gap = 0, err_burst = -1, b_idx = 0;
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_data[$];
  logic [AW-1:0] exp_aw_addr[$];
  int            exp_aw_len[$];
  int   cur_len = 0, beat_in_burst = 0, aw_cnt = 0, w_cnt = 0, done_cnt = 0;
  int   first_aw_cyc = -1, first_w_cyc = -1, last_b_cyc = -1, done_cyc = -1;
  logic pop_pending = 1'b0, gate = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO + AXI slave responder: a non-empty FIFO head stays valid until popped.
  initial begin
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = '0;
    bus.fifo_vld = 1'b0; bus.fifo_din = '0;
    forever begin
      @(posedge clk); #1;
      if (pop_pending && fifo_q.size() > 0) begin
        void'(fifo_q.pop_front());
        gate = (int'($urandom_range(99)) >= gap);
      end else if (!gate) begin
        gate = (int'($urandom_range(99)) >= gap);
      end
      pop_pending  = 1'b0;
      bus.fifo_vld = gate && (fifo_q.size() > 0);
      bus.fifo_din = (fifo_q.size() > 0) ? fifo_q[0] : '0;
      bus.awready  = (int'($urandom_range(99)) >= aw_stall);
      bus.wready   = (int'($urandom_range(99)) >= w_stall);
      bus.bvalid   = bus.bready && (int'($urandom_range(99)) >= b_stall);
      bus.bresp    = (b_idx == err_burst) ? 2'b10 : 2'b00;
    end
  end

  // Monitor: handshakes observed mid-cycle are the ones the next rising edge commits.
  initial begin
    logic          p_aw_stall, p_w_stall, p_wlast;
    logic [AW-1:0] p_awaddr, ea;
    logic [LW-1:0] p_awlen;
    logic [DW-1:0] p_wdata, ed;
    int            el;
    p_aw_stall = 1'b0; p_w_stall = 1'b0; p_wlast = 1'b0;
    p_awaddr = '0; p_awlen = '0; p_wdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        p_aw_stall = 1'b0; p_w_stall = 1'b0;
      end else begin
        if (p_aw_stall) begin
          vectors++;
          if (bus.awvalid !== 1'b1 || bus.awaddr !== p_awaddr || bus.awlen !== p_awlen) begin
            miscompares++;
            $display("FAIL aw_stable: awvalid=%b awaddr=%h awlen=%0d, required 1 %h %0d",
                     bus.awvalid, bus.awaddr, bus.awlen, p_awaddr, p_awlen);
          end
        end
        if (p_w_stall) begin
          vectors++;
          if (bus.wvalid !== 1'b1 || bus.wdata !== p_wdata || bus.wlast !== p_wlast) begin
            miscompares++;
            $display("FAIL w_stable: wvalid=%b wlast=%b wdata=%h, required 1 %b %h",
                     bus.wvalid, bus.wlast, bus.wdata, p_wlast, p_wdata);
          end
        end
        if (bus.wvalid || bus.fifo_rdy) begin
          vectors++;
          if (bus.fifo_rdy !== (bus.wvalid && bus.wready) || (bus.wvalid && !bus.fifo_vld)) begin
            miscompares++;
            $display("FAIL fifo_pop: fifo_rdy=%b wvalid=%b fifo_vld=%b wready=%b, required fifo_rdy=wvalid&wready",
                     bus.fifo_rdy, bus.wvalid, bus.fifo_vld, bus.wready);
          end
        end
        if (bus.awvalid && bus.awready) begin
          aw_cnt++;
          if (first_aw_cyc < 0) first_aw_cyc = cyc;
          vectors++;
          if (exp_aw_addr.size() == 0) begin
            miscompares++;
            $display("FAIL aw_extra: awaddr=%h awlen=%0d, required no burst", bus.awaddr, bus.awlen);
          end else begin
            ea = exp_aw_addr.pop_front();
            el = exp_aw_len.pop_front();
            cur_len = el; beat_in_burst = 0;
            if (bus.awaddr !== ea || bus.awlen !== LW'(el) || bus.awsize !== 3'd4 ||
                bus.awburst !== 2'b01 || bus.awcache !== 4'b0011 || bus.awprot !== 3'b000) begin
              miscompares++;
              $display("FAIL aw_burst: awaddr=%h awlen=%0d size=%0d burst=%0d cache=%0d prot=%0d, required %h %0d 4 1 3 0",
                       bus.awaddr, bus.awlen, bus.awsize, bus.awburst, bus.awcache, bus.awprot, ea, el);
            end
          end
        end
        if (bus.wvalid && bus.wready) begin
          w_cnt++;
          pop_pending = 1'b1;
          if (first_w_cyc < 0) first_w_cyc = cyc;
          vectors++;
          if (exp_data.size() == 0) begin
            miscompares++;
            $display("FAIL w_extra: wdata=%h, required no beat", bus.wdata);
          end else begin
            ed = exp_data.pop_front();
            if (bus.wdata !== ed || bus.wlast !== (beat_in_burst == cur_len) || bus.wstrb !== '1) begin
              miscompares++;
              $display("FAIL w_beat: wdata=%h wlast=%b wstrb=%h, required %h %b all-ones",
                       bus.wdata, bus.wlast, bus.wstrb, ed, (beat_in_burst == cur_len));
            end
          end
          beat_in_burst++;
        end
        if (bus.bvalid && bus.bready) begin b_idx++; last_b_cyc = cyc; end
        if (bus.done) begin done_cnt++; done_cyc = cyc; end
        p_aw_stall = bus.awvalid && !bus.awready; p_awaddr = bus.awaddr; p_awlen = bus.awlen;
        p_w_stall  = bus.wvalid && !bus.wready;   p_wdata  = bus.wdata;  p_wlast = bus.wlast;
      end
    end
  end

  task automatic clear_model();
    fifo_q.delete(); exp_data.delete(); exp_aw_addr.delete(); exp_aw_len.delete();
    aw_cnt = 0; w_cnt = 0; done_cnt = 0; b_idx = 0; pop_pending = 1'b0;
    first_aw_cyc = -1; first_w_cyc = -1; last_b_cyc = -1; done_cyc = -1;
  endtask

  // Loads the FIFO, predicts the burst list, and holds cmd_vld until accepted.
  task automatic start_cmd(input logic [AW-1:0] addr, input int len, output int t0);
    logic [AW-1:0] a;
    logic [DW-1:0] w;
    int r, b, room;
    @(posedge clk); #2;
    clear_model();
    for (int i = 0; i < len; i++) begin
      w = {$urandom, $urandom, $urandom, $urandom};
      fifo_q.push_back(w); exp_data.push_back(w);
    end
    a = addr & ~32'hF; r = len;
    while (r > 0) begin
      room = (4096 - int'(a[11:0])) / 16;
      b = (r < MAXB) ? r : MAXB;
      if (b > room) b = room;
      exp_aw_addr.push_back(a); exp_aw_len.push_back(b - 1);
      a = a + AW'(b * 16); r = r - b;
    end
    bus.cmd_addr = addr; bus.cmd_len = CW'(len); bus.cmd_vld = 1'b1;
    t0 = -1;
    for (int k = 0; k < 50 && t0 < 0; k++) begin
      @(negedge clk);
      if (bus.cmd_rdy) t0 = cyc;
    end
    vectors++;
    if (t0 < 0) begin miscompares++; $display("FAIL cmd_accept: cmd_rdy=0 for 50 cycles, required 1"); end
    @(posedge clk); #2;
    bus.cmd_vld = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit seen, output logic e);
    seen = 1'b0; e = 1'bx;
    for (int k = 0; k < limit && !seen; k++) begin
      @(negedge clk);
      if (bus.done) begin seen = 1'b1; e = bus.err; end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({bus.awvalid, bus.wvalid, bus.wlast, bus.bready, bus.fifo_rdy, bus.done, bus.err, bus.cmd_rdy} !== 8'h00 ||
        bus.awaddr !== '0 || bus.awlen !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: ctl=%b awaddr=%h awlen=%0d, required 00000000 0 0",
               {bus.awvalid, bus.wvalid, bus.wlast, bus.bready, bus.fifo_rdy, bus.done, bus.err, bus.cmd_rdy},
               bus.awaddr, bus.awlen);
    end
    @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); @(negedge clk);
    vectors++;
    if (bus.cmd_rdy !== 1'b1) begin miscompares++; $display("FAIL reset_cmd_rdy: %b, required 1", bus.cmd_rdy); end
  endtask

  task automatic test_single();
    int t0; bit seen; logic e;
    aw_stall = 0; w_stall = 0; b_stall = 0; gap = 0; err_burst = -1;
    start_cmd(32'h1000, 4, t0);
    wait_done(200, seen, e);
    vectors++;
    if (!seen || e !== 1'b0 || aw_cnt != 1 || w_cnt != 4 || done_cnt != 1) begin
      miscompares++;
      $display("FAIL single_counts: done=%0d err=%b aw=%0d w=%0d pulses=%0d, required 1 0 1 4 1",
               seen, e, aw_cnt, w_cnt, done_cnt);
    end
    vectors++;
    if (first_aw_cyc != t0 + 2 || first_w_cyc != t0 + 3 || done_cyc != last_b_cyc + 2) begin
      miscompares++;
      $display("FAIL single_latency: aw=%0d w=%0d done=%0d, required %0d %0d %0d",
               first_aw_cyc, first_w_cyc, done_cyc, t0 + 2, t0 + 3, last_b_cyc + 2);
    end
  endtask

  task automatic test_multi_burst();
    int t0; bit seen; logic e;
    start_cmd(32'h0, 40, t0);
    wait_done(500, seen, e);
    vectors++;
    if (!seen || e !== 1'b0 || aw_cnt != 3 || w_cnt != 40 || done_cnt != 1 || exp_data.size() != 0) begin
      miscompares++;
      $display("FAIL multi_burst: done=%0d err=%b aw=%0d w=%0d pulses=%0d left=%0d, required 1 0 3 40 1 0",
               seen, e, aw_cnt, w_cnt, done_cnt, exp_data.size());
    end
  endtask

  task automatic test_4k();
    int t0; bit seen; logic e;
    start_cmd(32'h0FC0, 8, t0);
    wait_done(300, seen, e);
    vectors++;
    if (!seen || aw_cnt != 2 || w_cnt != 8 || done_cnt != 1 || exp_aw_addr.size() != 0) begin
      miscompares++;
      $display("FAIL boundary_4k: done=%0d aw=%0d w=%0d pulses=%0d, required 1 2 8 1", seen, aw_cnt, w_cnt, done_cnt);
    end
  endtask

  task automatic test_random_stall();
    int t0, len, n_aw; bit seen; logic e;
    aw_stall = 30; w_stall = 30; b_stall = 30; gap = 30;
    for (int i = 0; i < 4; i++) begin
      len = (i == 0) ? 100 : int'($urandom_range(1, 60));
      start_cmd($urandom, len, t0);
      n_aw = exp_aw_addr.size();
      wait_done(4000, seen, e);
      vectors++;
      if (!seen || e !== 1'b0 || aw_cnt != n_aw || w_cnt != len || done_cnt != 1 || exp_data.size() != 0) begin
        miscompares++;
        $display("FAIL random_stall[%0d]: done=%0d err=%b aw=%0d w=%0d pulses=%0d, required 1 0 %0d %0d 1",
                 i, seen, e, aw_cnt, w_cnt, done_cnt, n_aw, len);
      end
    end
    aw_stall = 0; w_stall = 0; b_stall = 0; gap = 0;
  endtask

  task automatic test_bresp_err();
    int t0; bit seen; logic e;
    err_burst = 1;
    start_cmd(32'h0, 40, t0);
    wait_done(500, seen, e);
    vectors++;
    if (!seen || e !== 1'b1 || aw_cnt != 3 || w_cnt != 40 || done_cnt != 1) begin
      miscompares++;
      $display("FAIL bresp_err: done=%0d err=%b aw=%0d w=%0d, required 1 1 3 40", seen, e, aw_cnt, w_cnt);
    end
    err_burst = -1;
    start_cmd(32'h2000, 4, t0);
    @(negedge clk);
    vectors++;
    if (bus.err !== 1'b0) begin miscompares++; $display("FAIL err_clear: err=%b, required 0", bus.err); end
    wait_done(200, seen, e);
    vectors++;
    if (!seen || e !== 1'b0) begin miscompares++; $display("FAIL err_next_cmd: done=%0d err=%b, required 1 0", seen, e); end
  endtask

  task automatic test_len0();
    int t0; bit seen; logic e;
    start_cmd(32'h40, 0, t0);
    wait_done(50, seen, e);
    vectors++;
    if (!seen || done_cyc != t0 + 2 || aw_cnt != 0 || w_cnt != 0 || done_cnt != 1) begin
      miscompares++;
      $display("FAIL len_zero: done=%0d at %0d aw=%0d w=%0d pulses=%0d, required 1 at %0d 0 0 1",
               seen, done_cyc, aw_cnt, w_cnt, done_cnt, t0 + 2);
    end
  endtask

  task automatic test_reset_mid_burst();
    int t0; bit got, seen; logic e;
    start_cmd(32'h0, 40, t0);
    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin @(negedge clk); got = bus.wvalid; end
    vectors++;
    if (!got) begin miscompares++; $display("FAIL reach_w: wvalid=0 for 100 cycles, required 1"); end
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); @(negedge clk);
    vectors++;
    if ({bus.awvalid, bus.wvalid, bus.wlast, bus.bready, bus.fifo_rdy, bus.done, bus.cmd_rdy} !== 7'h00 ||
        bus.awaddr !== '0 || bus.awlen !== '0) begin
      miscompares++;
      $display("FAIL mid_reset: ctl=%b awaddr=%h awlen=%0d, required 0000000 0 0",
               {bus.awvalid, bus.wvalid, bus.wlast, bus.bready, bus.fifo_rdy, bus.done, bus.cmd_rdy},
               bus.awaddr, bus.awlen);
    end
    clear_model();
    @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); @(negedge clk);
    vectors++;
    if (bus.cmd_rdy !== 1'b1 || bus.awvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset: cmd_rdy=%b awvalid=%b, required 1 0", bus.cmd_rdy, bus.awvalid);
    end
    start_cmd(32'h3000, 4, t0);
    wait_done(200, seen, e);
    vectors++;
    if (!seen || aw_cnt != 1 || w_cnt != 4 || done_cnt != 1) begin
      miscompares++;
      $display("FAIL recover: done=%0d aw=%0d w=%0d pulses=%0d, required 1 1 4 1", seen, aw_cnt, w_cnt, done_cnt);
    end
  endtask

  initial begin
    bus.cmd_addr = '0; bus.cmd_len = '0; bus.cmd_vld = 1'b0;
    clear_model();
    test_reset();
    test_single();
    test_multi_burst();
    test_4k();
    test_random_stall();
    test_bresp_err();
    test_len0();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
